// File: rtl/streebog_pkg.sv
// Shared constants and FSM state type for the Streebog block packer.
package streebog_pkg;

    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 512;
    localparam int WORDS_PER_BLOCK = 16;
    localparam logic [7:0] PAD_BYTE = 8'h01;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        FILL,
        UPD,
        PADBLK,
        FIN,
        SETTLE,
        WAIT
    } state_t;

endpackage

// File: rtl/streebog_pad_mask.sv
// Last-word byte masking and padding position for the block packer.
// Optional STREEBOG_PACKER_BYTE_SWAP_EN reverses byte order of the incoming word.
module streebog_pad_mask
    import streebog_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        bytes,
    input  logic [3:0]        idx,
    output logic [WORD_W-1:0] masked_word,
    output logic [6:0]        pad_pos
);

    logic [WORD_W-1:0] ordered;
    logic [2:0]        nbytes;

`ifdef STREEBOG_PACKER_BYTE_SWAP_EN
    assign ordered = {word[7:0], word[15:8], word[23:16], word[31:24]};
`else
    assign ordered = word;
`endif

    // pad_pos is the total byte count n = 4*idx + bytes; 64 means the block is full
    always_comb begin
        nbytes      = (bytes == 2'd0) ? 3'd4 : {1'b0, bytes};
        masked_word = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < nbytes) begin
                masked_word[8*b +: 8] = ordered[8*b +: 8];
            end
        end
        pad_pos = {1'b0, idx, 2'b00} + {4'b0000, nbytes};
    end

endmodule

// File: rtl/streebog_block_packer.sv
// Packs a 32-bit word stream into padded 512-bit Streebog blocks and sequences
// the core's init/update/final commands. Build option: STREEBOG_PACKER_BYTE_SWAP_EN.
module streebog_block_packer
    import streebog_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               s_start,
    input  logic               s_short_mode,
    input  logic [WORD_W-1:0]  s_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_last,
    input  logic [1:0]         s_bytes,
    output logic [BLOCK_W-1:0] h_block,
    output logic [9:0]         h_block_length,
    output logic               h_init,
    output logic               h_update,
    output logic               h_final,
    output logic               h_short_mode,
    input  logic               h_ready,
    output logic               busy,
    output state_t             dbg_state
);

    // Stream handshake: a word moves on a clock edge where s_valid && s_ready;
    // s_ready depends only on the FSM state, never on s_valid.

    state_t             state, state_next;
    state_t             ret_state, ret_next;
    logic [3:0]         idx;
    logic [BLOCK_W-1:0] block;
    logic [9:0]         length;
    logic               short_mode;
    logic               busy_q;
    logic [WORD_W-1:0]  masked_word;
    logic [6:0]         pad_pos;
    logic               last_full;

    streebog_pad_mask u_pad_mask (
        .word        (s_data),
        .bytes       (s_last ? s_bytes : 2'd0),
        .idx         (idx),
        .masked_word (masked_word),
        .pad_pos     (pad_pos)
    );

    assign last_full      = (pad_pos == 7'd64);
    assign h_block        = block;
    assign h_block_length = length;
    assign h_short_mode   = short_mode;
    assign busy           = busy_q;
    assign dbg_state      = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ret_state <= IDLE;
        end else begin
            state     <= state_next;
            ret_state <= ret_next;
        end
    end

    always_comb begin
        state_next = state;
        ret_next   = ret_state;
        s_ready    = 1'b0;
        h_init     = 1'b0;
        h_update   = 1'b0;
        h_final    = 1'b0;
        case (state)
            IDLE: begin
                if (s_start) state_next = INIT;
            end
            INIT: begin
                h_init     = 1'b1;
                ret_next   = FILL;
                state_next = SETTLE;
            end
            FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (s_last) begin
                        state_next = UPD;
                        ret_next   = last_full ? PADBLK : FIN;
                    end else if (idx == 4'(WORDS_PER_BLOCK - 1)) begin
                        state_next = UPD;
                        ret_next   = FILL;
                    end
                end
            end
            UPD: begin
                h_update   = 1'b1;
                state_next = SETTLE;
            end
            PADBLK: begin
                h_update   = 1'b1;
                ret_next   = FIN;
                state_next = SETTLE;
            end
            FIN: begin
                h_final    = 1'b1;
                ret_next   = IDLE;
                state_next = SETTLE;
            end
            SETTLE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (h_ready) state_next = ret_state;
            end
            default: state_next = IDLE;
        endcase
    end

    // Block contents change only in FILL or on leaving WAIT, so they stay
    // stable from an update pulse until the core reports ready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            block      <= '0;
            length     <= '0;
            idx        <= '0;
            short_mode <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_start) begin
                        short_mode <= s_short_mode;
                        busy_q     <= 1'b1;
                    end
                end
                FILL: begin
                    if (s_valid) begin
                        block[{idx, 5'b00000} +: WORD_W] <= masked_word;
                        if (s_last && !last_full) begin
                            block[{pad_pos[5:0], 3'b000} +: 8] <= PAD_BYTE;
                            length <= {pad_pos, 3'b000};
                        end else begin
                            length <= 10'(BLOCK_W);
                        end
                        idx <= idx + 4'd1;
                    end
                end
                WAIT: begin
                    if (h_ready) begin
                        case (ret_state)
                            FILL: begin
                                block <= '0;
                                idx   <= '0;
                            end
                            PADBLK: begin
                                block  <= BLOCK_W'(1);
                                length <= '0;
                            end
                            IDLE:    busy_q <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_streebog_block_packer.sv
// Directed bench for streebog_block_packer with a stalling core model and block scoreboard.
module tb_streebog_block_packer;
    import streebog_pkg::*;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         s_start = 1'b0;
    logic         s_short_mode = 1'b0;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    logic [1:0]   s_bytes = '0;
    logic         h_ready = 1'b1;
    logic         s_ready, h_init, h_update, h_final, h_short_mode, busy;
    logic [511:0] h_block;
    logic [9:0]   h_block_length;
    state_t       dbg_state;

    int checks = 0;
    int failures = 0;
    int init_cnt = 0;
    int update_cnt = 0;
    int final_cnt = 0;
    int stall_cycles = 0;
    logic [511:0] exp_q[$];
    logic [9:0]   exp_len_q[$];
    logic [7:0]   msg[$];
    logic [511:0] last_blk = '0;
    logic [9:0]   last_len = '0;

    logic [511:0] hold_blk = '0;
    logic [511:0] eb;
    logic [9:0]   el;
    int           stall = 0;
    bit           held = 0;

    streebog_block_packer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .s_start        (s_start),
        .s_short_mode   (s_short_mode),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_last         (s_last),
        .s_bytes        (s_bytes),
        .h_block        (h_block),
        .h_block_length (h_block_length),
        .h_init         (h_init),
        .h_update       (h_update),
        .h_final        (h_final),
        .h_short_mode   (h_short_mode),
        .h_ready        (h_ready),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Core model: observes pulses on the falling edge, scores updates, drops h_ready for stall_cycles.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                stall   = 0;
                held    = 0;
                h_ready = 1'b1;
            end else begin
                if (h_init || h_update || h_final) begin
                    checks++;
                    if (int'(h_init) + int'(h_update) + int'(h_final) > 1) begin
                        failures++;
                        $display("FAIL pulse_onehot: init=%b update=%b final=%b, required at most one high",
                                 h_init, h_update, h_final);
                    end
                end
                if (stall > 0 && held) begin
                    checks++;
                    if (h_block !== hold_blk || s_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL stall_hold: s_ready=%b block_changed=%b, required s_ready=0 and stable block",
                                 s_ready, h_block !== hold_blk);
                    end
                end
                if (h_init) init_cnt++;
                if (h_update) begin
                    update_cnt++;
                    last_blk = h_block;
                    last_len = h_block_length;
                    hold_blk = h_block;
                    held     = 1;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_update: got length %0d with no block expected", h_block_length);
                    end else begin
                        eb = exp_q.pop_front();
                        el = exp_len_q.pop_front();
                        if (h_block !== eb || h_block_length !== el) begin
                            failures++;
                            $display("FAIL update_block: got len %0d blk %h, required len %0d blk %h",
                                     h_block_length, h_block, el, eb);
                        end
                    end
                end
                if (h_final) begin
                    final_cnt++;
                    held = 0;
                end
                if (h_update || h_final) stall = stall_cycles;
                else if (stall > 0) stall--;
                h_ready = (stall == 0);
            end
        end
    end

    task automatic build_msg(input int len, input int kind);
        msg.delete();
        for (int i = 0; i < len; i++) begin
            if (kind == 0) msg.push_back(8'(8'h30 + i % 10));
            else           msg.push_back(8'(i * 7 + 3));
        end
    endtask

    // Expected blocks: full 64-byte chunks, then either a padded tail or a lone 0x01 block.
    task automatic queue_expected(input int len);
        logic [511:0] blk;
        int full;
        int rem;
        full = len / 64;
        rem  = len % 64;
        for (int b = 0; b < full; b++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk[8*j +: 8] = msg[64*b + j];
            exp_q.push_back(blk);
            exp_len_q.push_back(10'd512);
        end
        if (rem == 0) begin
            blk = '0;
            blk[0] = 1'b1;
            exp_q.push_back(blk);
            exp_len_q.push_back(10'd0);
        end else begin
            blk = '0;
            for (int j = 0; j < rem; j++) blk[8*j +: 8] = msg[64*full + j];
            blk[8*rem +: 8] = 8'h01;
            exp_q.push_back(blk);
            exp_len_q.push_back(10'(8 * rem));
        end
    endtask

    task automatic send_msg(input int len, input logic mode, input bit rand_valid,
                            input int stop_at, input int glitch_at);
        int nwords;
        int cyc;
        int k;
        bit acc;
        logic [31:0] w;
        logic [7:0] bv;
        queue_expected(len);
        @(negedge clock);
        s_start      = 1'b1;
        s_short_mode = mode;
        @(negedge clock);
        s_start      = 1'b0;
        s_short_mode = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_rise: got %b required 1", busy);
        end
        nwords = (len + 3) / 4;
        for (int wi = 0; wi < nwords; wi++) begin
            if (wi == stop_at) begin
                s_valid = 1'b0;
                return;
            end
            w = '0;
            for (int b = 0; b < 4; b++) begin
                k  = 4 * wi + b;
                bv = (k < len) ? msg[k] : 8'hA5;
`ifdef STREEBOG_PACKER_BYTE_SWAP_EN
                w[31 - 8*b -: 8] = bv;
`else
                w[8*b +: 8] = bv;
`endif
            end
            s_data  = w;
            s_last  = (wi == nwords - 1);
            s_bytes = s_last ? 2'(len % 4) : 2'd0;
            acc = 0;
            cyc = 0;
            while (!acc && cyc < 500) begin
                s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                s_start = (wi == glitch_at && cyc == 0);
                #1;
                if (s_valid && s_ready) acc = 1;
                @(negedge clock);
                cyc++;
            end
            s_start = 1'b0;
            checks++;
            if (!acc) begin
                failures++;
                $display("FAIL word_accept: word %0d not accepted within %0d cycles", wi, cyc);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_bytes = 2'd0;
        cyc = 0;
        while (busy && cyc < 2000) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_drop: got %b required 0 after %0d cycles", busy, cyc);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({s_ready, h_init, h_update, h_final, busy, h_short_mode} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {s_ready, h_init, h_update, h_final, busy, h_short_mode});
        end
        checks++;
        if (h_block !== '0 || h_block_length !== 10'd0) begin
            failures++;
            $display("FAIL reset_block: got len %0d block_nonzero=%b required 0", h_block_length, |h_block);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_63_bytes();
        int i0, u0, f0;
        i0 = init_cnt; u0 = update_cnt; f0 = final_cnt;
        build_msg(63, 0);
        send_msg(63, 1'b0, 0, -1, -1);
        checks++;
        if (init_cnt - i0 != 1 || update_cnt - u0 != 1 || final_cnt - f0 != 1) begin
            failures++;
            $display("FAIL m63_pulses: got init %0d upd %0d fin %0d required 1 1 1",
                     init_cnt - i0, update_cnt - u0, final_cnt - f0);
        end
        checks++;
        if (last_len !== 10'd504 || last_blk[511:504] !== 8'h01) begin
            failures++;
            $display("FAIL m63_pad: got len %0d top byte %h required 504 01", last_len, last_blk[511:504]);
        end
        checks++;
        if (h_short_mode !== 1'b0) begin
            failures++;
            $display("FAIL m63_mode: got %b required 0", h_short_mode);
        end
    endtask

    task automatic test_72_bytes();
        int u0, f0;
        u0 = update_cnt; f0 = final_cnt;
        build_msg(72, 1);
        send_msg(72, 1'b1, 0, -1, -1);
        checks++;
        if (update_cnt - u0 != 2 || final_cnt - f0 != 1) begin
            failures++;
            $display("FAIL m72_pulses: got upd %0d fin %0d required 2 1", update_cnt - u0, final_cnt - f0);
        end
        checks++;
        if (last_len !== 10'd64 || last_blk[71:64] !== 8'h01 || last_blk[511:72] !== '0) begin
            failures++;
            $display("FAIL m72_pad: got len %0d pad %h upper_nonzero=%b required 64 01 0",
                     last_len, last_blk[71:64], |last_blk[511:72]);
        end
        checks++;
        if (h_short_mode !== 1'b1) begin
            failures++;
            $display("FAIL m72_mode: got %b required 1", h_short_mode);
        end
    endtask

    task automatic test_64_bytes();
        int u0, f0;
        u0 = update_cnt; f0 = final_cnt;
        build_msg(64, 0);
        send_msg(64, 1'b0, 0, -1, -1);
        checks++;
        if ((update_cnt - u0) + (final_cnt - f0) != 3 || final_cnt - f0 != 1) begin
            failures++;
            $display("FAIL m64_pulses: got upd %0d fin %0d required 2 1", update_cnt - u0, final_cnt - f0);
        end
        checks++;
        if (last_len !== 10'd0 || last_blk !== 512'h1) begin
            failures++;
            $display("FAIL m64_padblk: got len %0d low byte %h required 0 01", last_len, last_blk[7:0]);
        end
    endtask

    task automatic test_stall();
        int u0, f0;
        u0 = update_cnt; f0 = final_cnt;
        stall_cycles = 20;
        build_msg(100, 1);
        send_msg(100, 1'b0, 1, -1, -1);
        stall_cycles = 0;
        checks++;
        if (update_cnt - u0 != 2 || final_cnt - f0 != 1) begin
            failures++;
            $display("FAIL stall_pulses: got upd %0d fin %0d required 2 1", update_cnt - u0, final_cnt - f0);
        end
        checks++;
        if (last_len !== 10'd288) begin
            failures++;
            $display("FAIL stall_len: got %0d required 288", last_len);
        end
    endtask

    task automatic test_reset_mid();
        int i0, u0, f0;
        build_msg(100, 1);
        send_msg(100, 1'b1, 0, 7, -1);
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b1 || h_block === '0) begin
            failures++;
            $display("FAIL mid_fill: got s_ready %b busy %b required 1 1 with data", s_ready, busy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, busy, h_short_mode, h_init, h_update, h_final} !== 6'b0 || h_block !== '0
            || h_block_length !== 10'd0) begin
            failures++;
            $display("FAIL async_reset: got ctrl %b block_nonzero %b required 0",
                     {s_ready, busy, h_short_mode, h_init, h_update, h_final}, |h_block);
        end
        exp_q.delete();
        exp_len_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        i0 = init_cnt; u0 = update_cnt; f0 = final_cnt;
        send_msg(100, 1'b0, 0, -1, -1);
        checks++;
        if (init_cnt - i0 != 1 || update_cnt - u0 != 2 || final_cnt - f0 != 1) begin
            failures++;
            $display("FAIL after_reset: got init %0d upd %0d fin %0d required 1 2 1",
                     init_cnt - i0, update_cnt - u0, final_cnt - f0);
        end
    endtask

    task automatic test_ignore();
        int i0, u0, f0;
        bit seen_ready;
        i0 = init_cnt; u0 = update_cnt; f0 = final_cnt;
        seen_ready = 0;
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        s_last  = 1'b1;
        repeat (6) begin
            @(negedge clock);
            #1;
            if (s_ready) seen_ready = 1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++;
        if (seen_ready || dbg_state !== IDLE || update_cnt != u0) begin
            failures++;
            $display("FAIL idle_valid: got ready_seen %b state %0d required 0 %0d", seen_ready, dbg_state, IDLE);
        end
        build_msg(40, 0);
        send_msg(40, 1'b0, 0, -1, 3);
        checks++;
        if (init_cnt - i0 != 1 || update_cnt - u0 != 1 || final_cnt - f0 != 1) begin
            failures++;
            $display("FAIL start_busy: got init %0d upd %0d fin %0d required 1 1 1",
                     init_cnt - i0, update_cnt - u0, final_cnt - f0);
        end
        checks++;
        if (last_len !== 10'd320) begin
            failures++;
            $display("FAIL start_busy_len: got %0d required 320", last_len);
        end
    endtask

    initial begin
        test_reset();
        test_63_bytes();
        test_72_bytes();
        test_64_bytes();
        test_stall();
        test_reset_mid();
        test_ignore();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover: %0d expected blocks never seen, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/streebog_block_packer.md
Name: streebog_block_packer

Overview:
Upstream front end for streebog_hash_top. It accepts a message as a stream of 32-bit words and assembles 512-bit blocks, least-significant word first. It applies Streebog padding: a 0x01 byte directly above the last message byte, zero fill above that. It then drives the core's init/update/final pulses and respects the core's `ready`. One message is processed at a time.

Parameters:
- WORD_W, 32, input word width in bits; fixed, one word carries 4 bytes.
- BLOCK_W, 512, block width in bits.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_start  in  1  one-cycle pulse that begins a message; sampled only in IDLE.
- s_short_mode  in  1  256-bit mode select; captured together with s_start.
- s_data  in  32  message word; byte 0 is in bits [7:0].
- s_valid  in  1  s_data is valid.
- s_ready  out  1  packer accepts a word when s_valid && s_ready.
- s_last  in  1  marks the final word of the message.
- s_bytes  in  2  number of valid bytes in the last word; 0 means 4, 1..3 are literal counts.
- h_block  out  512  block to the core.
- h_block_length  out  10  valid message bits in h_block, range 0..512.
- h_init / h_update / h_final  out  1  one-cycle command pulses to the core.
- h_short_mode  out  1  registered mode bit.
- h_ready  in  1  core ready.
- busy  out  1  high from the s_start cycle until the final command completes.

Behaviour:
- Reset values: s_ready=0, h_init=0, h_update=0, h_final=0, busy=0, h_block=0, h_block_length=0, h_short_mode=0. The FSM resets to IDLE.
- Reset mid-operation aborts immediately. The core is not notified; the next message starts with h_init.
- FSM states: IDLE, INIT, FILL, UPD, PADBLK, FIN, SETTLE, WAIT.
- IDLE: s_ready=0. On s_start: capture the mode, set busy=1, go to INIT. s_valid is ignored in IDLE.
- INIT: pulse h_init for one cycle, then go to SETTLE.
- SETTLE: wait one cycle; h_ready is ignored. Then go to WAIT.
- WAIT: stay until h_ready=1, then go to the recorded next state (FILL, PADBLK, FIN or IDLE).
- FILL: s_ready=1. Each accepted word is written to bits [32*idx+31 : 32*idx]; the 4-bit idx then increments. At the start of each block, clear the block and idx.
- FILL, word idx=15 without s_last: set length 512 and go to UPD. Next state after WAIT is FILL.
- FILL, word with s_last: n = 4*idx + bytes(s_bytes), giving 1..64 bytes.
  - If n<64: write 0x01 at byte n, keep the upper bytes zero, set length 8*n, go to UPD. Next state after WAIT is FIN.
  - If n=64: set length 512 and go to UPD. Next state after WAIT is PADBLK.
- Unused bytes of a partial last word are forced to zero, whatever s_data holds there.
- UPD: h_update pulses for one cycle, then go to SETTLE. s_ready=0 from UPD until the FSM re-enters FILL.
- PADBLK: load block = 512'h1, length 0, and pulse h_update. Next state after WAIT is FIN.
- FIN: pulse h_final, then go to SETTLE. Next state after WAIT is IDLE, and busy drops on that transition.
- h_block and h_block_length hold stable from the update pulse until the core is ready again.
- s_start while busy is ignored.
- A zero-length message is not supported.
- Never more than one h_* pulse is high in any cycle.

Optional Feature:
- Macro: STREEBOG_PACKER_BYTE_SWAP_EN.
- When defined, s_data is byte-reversed before packing: bits [31:24] become byte 0. This suits big-endian upstream sources. s_bytes then counts from the most significant byte.
- When undefined, no swap is applied; byte 0 is s_data[7:0].

Decomposition:
- Package streebog_pkg holds:
  - the FSM state typedef;
  - BLOCK_W, WORD_W and WORDS_PER_BLOCK=16;
  - PAD_BYTE=8'h01.
- One sub-module, streebog_pad_mask: combinational. Inputs are the last word, byte count and idx; outputs are the masked word and the padding-insert position. The FSM stays in the top level.

Test Plan:
- 63-byte ASCII "0123456789" repeated, s_last on word 15 with s_bytes=3: one update with h_block_length=504 and h_block[511:504]=8'h01; then h_final. A core in 512-bit mode gives digest 486f64c1…1ad0541b.
- 72-byte message: first update has length 512; second update has length 64 with h_block[71:64]=8'h01 and bits above zero. 256-bit mode digest is 508f7e55…4efed29d.
- Exactly 64 bytes: update with length 512, then update with block=512'h1 and length 0, then h_final. Exactly three command pulses follow h_init.
- Core holds h_ready=0 for 20 cycles after each update: s_ready stays 0, h_block stays stable, and no words are lost. s_valid toggling randomly gives the same block contents.
- reset_n asserted during FILL at idx=7: all outputs return to their reset values asynchronously. A following full message behaves exactly like a fresh run.
- s_start pulsed while busy, and s_valid held high in IDLE: no effect, no extra h_init, no word accepted.
